if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction fetch stage for the 5-stage pipeline. Holds the PC and issues one-at-a-time requests to a variable-latency instruction memory. Drives the instruction and PC+4 into the IF/ID pipeline register, honouring the hazard unit's stall and the branch/jump redirect. When no valid instruction is available it presents a NOP (all-zero word), so IF/ID loads a bubble without extra control.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset; must be word-aligned.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- CStall  in  1  hazard-unit stall; IF/ID is holding its contents this cycle.
- CRedirect  in  1  taken branch/jump; fetch must restart at IRedirectPC.
- IRedirectPC  in  32  redirect target; bits [1:0] ignored, stored as 00.
- OMemReq  out  1  instruction request valid.
- OMemAddr  out  32  request address (current PC).
- IMemReady  in  1  memory accepts request this cycle (request handshake = OMemReq & IMemReady).
- IMemValid  in  1  response valid; never in the same cycle as its acceptance (min latency 1).
- IMemData  in  32  response instruction word.
- OValid  out  1  OInst/OPCAdd4 carry a real instruction this cycle.
- OInst  out  32  instruction to IF/ID; 32'b0 when OValid=0.
- OPCAdd4  out  32  PC+4 of the presented instruction (always PC+4).

## Operation
- Registers: PC[31:0], state, hold buffer HBuf[31:0].
- States: S_REQ (issue request), S_WAIT (one request outstanding), S_HOLD (instruction captured, IF/ID stalled), S_DRAIN (discard stale outstanding response).
- Outputs are combinational from state/inputs:
  - OMemReq = (state==S_REQ) & !CRedirect & !reset.
  - OMemAddr = PC.
  - OValid = ((S_WAIT & IMemValid) | S_HOLD) & !CRedirect.
  - OInst = OValid ? (S_HOLD ? HBuf : IMemData) : 0.
  - OPCAdd4 = PC+4, modulo 2^32; wraps 32'hFFFF_FFFC to 0.
- Transitions (CRedirect has priority over everything; on redirect, PC <= {IRedirectPC[31:2],2'b00}):
  - S_REQ: redirect → S_REQ. Else if IMemReady → S_WAIT. Else stay.
  - S_WAIT, IMemValid=1:
    - Redirect → S_REQ (response dropped).
    - Else if CStall → HBuf <= IMemData, go S_HOLD.
    - Else PC <= PC+4, go S_REQ.
  - S_WAIT, IMemValid=0: redirect → S_DRAIN. Else stay.
  - S_HOLD:
    - Redirect → S_REQ (HBuf dropped).
    - Else if !CStall → PC <= PC+4, go S_REQ.
    - Else stay, keep presenting HBuf.
  - S_DRAIN:
    - IMemValid → S_REQ; response never presented, OValid=0.
    - A further redirect updates PC and stays S_DRAIN (or goes S_REQ if IMemValid is high in the same cycle).
- IMemValid in S_REQ or S_HOLD is a protocol violation; ignore it.

## Timing
- Reset (async): PC=RESET_PC, state=S_REQ, HBuf=0. While reset is high: OMemReq=0, OValid=0, OInst=0, OMemAddr=RESET_PC, OPCAdd4=RESET_PC+4.
- First request is asserted in the first cycle after reset deasserts.
- Throughput: one instruction per 2 cycles with IMemReady=1 and latency 1 (request cycle, response cycle).
- Instruction is presented in the cycle IMemValid is high. IF/ID captures it on that edge unless CStall is high.
- Stall in the response cycle: the same instruction and OPCAdd4 are presented every cycle until the first cycle with CStall=0. PC advances on that edge.
- Redirect takes effect on the next edge. OValid is forced low in the redirect cycle.
- Reset mid-S_WAIT/S_DRAIN: back to S_REQ. The memory response still in flight arrives in S_REQ and is ignored.

## Test plan
- Reset release, IMemReady=1, latency 1, IMemData=32'h2008_0001 then 32'h2009_0002:
  - Addresses 0x0040_0000, then 0x0040_0004.
  - OValid on alternate cycles; OPCAdd4 = 0x0040_0004, then 0x0040_0008.
- IMemReady low for 3 cycles: OMemReq held high, OMemAddr stable at 0x0040_0000, OValid=0, OInst=0.
- CStall high for 2 cycles from the response cycle: OInst stable for 3 cycles, no new OMemReq. PC reaches 0x0040_0004 only after CStall drops.
- CRedirect to 0x0040_0100 while in S_WAIT with latency 3:
  - Stale response is not presented (OValid=0).
  - Next OMemAddr = 0x0040_0100.
- CRedirect to 0x0040_0203 in the same cycle as IMemValid and CStall: OValid=0, next OMemAddr = 0x0040_0200, no S_HOLD entry.
- reset pulse during S_WAIT, then a late IMemValid: ignored. OMemAddr = 0x0040_0000 after release; no spurious OValid.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one outstanding request, feeds IF/ID.
// Latency: response presented combinationally in the cycle IMemValid is high.
// Backpressure: IMemReady low holds the request; CStall parks the instruction in a hold buffer.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   CStall                  IF/ID is holding its contents this cycle
//   CRedirect, IRedirectPC  taken branch/jump and its target (bits [1:0] ignored)
//   OMemReq, OMemAddr       instruction request valid and address (current PC)
//   IMemReady               memory accepts the request this cycle
//   IMemValid, IMemData     instruction response (at least one cycle after acceptance)
//   OValid, OInst, OPCAdd4  instruction presented to IF/ID (all-zero NOP when not valid) and PC+4
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CStall,
    input  logic        CRedirect,
    input  logic [31:0] IRedirectPC,
    output logic        OMemReq,
    output logic [31:0] OMemAddr,
    input  logic        IMemReady,
    input  logic        IMemValid,
    input  logic [31:0] IMemData,
    output logic        OValid,
    output logic [31:0] OInst,
    output logic [31:0] OPCAdd4
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hbuf;

    logic [31:0] w_pc_add4;
    logic [31:0] w_redirect_pc;
    logic        w_resp_vld;

    // Adder wraps naturally at 2^32.
    assign w_pc_add4     = r_pc + 32'd4;
    assign w_redirect_pc = {IRedirectPC[31:2], 2'b00};

    // A real instruction is available either straight from memory or from the hold buffer.
    // Responses in S_REQ/S_HOLD are protocol violations and S_DRAIN responses are stale,
    // so only S_WAIT lets IMemValid through.
    assign w_resp_vld = ((r_state == S_WAIT) && IMemValid) || (r_state == S_HOLD);

    assign OMemReq  = (r_state == S_REQ) && !CRedirect && !reset;
    assign OMemAddr = r_pc;
    assign OValid   = w_resp_vld && !CRedirect;
    assign OInst    = !OValid ? 32'h0 : ((r_state == S_HOLD) ? r_hbuf : IMemData);
    assign OPCAdd4  = w_pc_add4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_hbuf  <= 32'h0;
        end else if (CRedirect) begin
            r_pc <= w_redirect_pc;
            // A request still in flight must be drained before a new one can be issued,
            // otherwise its response would be mistaken for the redirect target.
            case (r_state)
                S_WAIT:  r_state <= IMemValid ? S_REQ : S_DRAIN;
                S_DRAIN: r_state <= IMemValid ? S_REQ : S_DRAIN;
                default: r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (IMemReady) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (IMemValid) begin
                        if (CStall) begin
                            r_hbuf  <= IMemData;
                            r_state <= S_HOLD;
                        end else begin
                            r_pc    <= w_pc_add4;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!CStall) begin
                        r_pc    <= w_pc_add4;
                        r_state <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (IMemValid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: scenario tasks with a scoreboard of expected instructions.
// Latency: inputs driven at negedge, outputs sampled 1ns later, state advances on posedge.
// Backpressure: IMemReady, CStall and CRedirect are driven directly by each scenario.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        CStall;
    logic        CRedirect;
    logic [31:0] IRedirectPC;
    logic        OMemReq;
    logic [31:0] OMemAddr;
    logic        IMemReady;
    logic        IMemValid;
    logic [31:0] IMemData;
    logic        OValid;
    logic [31:0] OInst;
    logic [31:0] OPCAdd4;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp;
    int   n_err;

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .CStall      (CStall),
        .CRedirect   (CRedirect),
        .IRedirectPC (IRedirectPC),
        .OMemReq     (OMemReq),
        .OMemAddr    (OMemAddr),
        .IMemReady   (IMemReady),
        .IMemValid   (IMemValid),
        .IMemData    (IMemData),
        .OValid      (OValid),
        .OInst       (OInst),
        .OPCAdd4     (OPCAdd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next negedge, drive all inputs, let outputs settle.
    task automatic tick(input logic rdy, input logic vld, input logic stall,
                        input logic redir, input logic [31:0] rpc, input logic [31:0] data);
        @(negedge clk);
        IMemReady   = rdy;
        IMemValid   = vld;
        CStall      = stall;
        CRedirect   = redir;
        IRedirectPC = rpc;
        IMemData    = data;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        IMemReady = 0; IMemValid = 0; CStall = 0; CRedirect = 0; IRedirectPC = 0; IMemData = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // One request at addr accepted immediately, answered next cycle with data, no stall.
    task automatic fetch_one(input logic [31:0] data, input logic [31:0] addr);
        tick(1, 0, 0, 0, 32'h0, 32'hDEAD_BEEF);
        n_cmp++; if (OMemReq !== 1'b1) begin n_err++; $display("FAIL fetch_req got %b exp 1", OMemReq); end
        n_cmp++; if (OMemAddr !== addr) begin n_err++; $display("FAIL fetch_addr got %h exp %h", OMemAddr, addr); end
        n_cmp++; if (OValid !== 1'b0) begin n_err++; $display("FAIL fetch_idle_valid got %b exp 0", OValid); end
        sb.push_back('{inst: data, pc4: addr + 32'd4});
        tick(0, 1, 0, 0, 32'h0, data);
        n_cmp++; if (OMemReq !== 1'b0) begin n_err++; $display("FAIL fetch_resp_req got %b exp 0", OMemReq); end
        n_cmp++;
        if (OValid !== 1'b1 || sb.size() == 0) begin
            n_err++; $display("FAIL fetch_valid got %b exp 1 (queued %0d)", OValid, sb.size());
        end else begin
            e = sb.pop_front();
            n_cmp++; if (OInst !== e.inst) begin n_err++; $display("FAIL fetch_inst got %h exp %h", OInst, e.inst); end
            n_cmp++; if (OPCAdd4 !== e.pc4) begin n_err++; $display("FAIL fetch_pc4 got %h exp %h", OPCAdd4, e.pc4); end
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_cmp++; if (OMemReq !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", OMemReq); end
        n_cmp++; if (OValid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", OValid); end
        n_cmp++; if (OInst !== 32'h0) begin n_err++; $display("FAIL rst_inst got %h exp 0", OInst); end
        n_cmp++; if (OMemAddr !== RESET_PC) begin n_err++; $display("FAIL rst_addr got %h exp %h", OMemAddr, RESET_PC); end
        n_cmp++; if (OPCAdd4 !== RESET_PC + 32'd4) begin n_err++; $display("FAIL rst_pc4 got %h exp %h", OPCAdd4, RESET_PC + 32'd4); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (OMemReq !== 1'b1) begin n_err++; $display("FAIL rst_first_req got %b exp 1", OMemReq); end
    endtask

    task automatic test_stream();
        logic [31:0] tbl [4];
        tbl[0] = 32'h2008_0001; tbl[1] = 32'h2009_0002; tbl[2] = 32'h0128_5020; tbl[3] = 32'hAC0A_0000;
        for (int k = 0; k < 4; k++) fetch_one(tbl[k], RESET_PC + 32'(4 * k));
    endtask

    task automatic test_not_ready();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 0, 0, 32'h0, 32'hDEAD_BEEF);
            n_cmp++; if (OMemReq !== 1'b1) begin n_err++; $display("FAIL nrdy_req cyc %0d got %b exp 1", k, OMemReq); end
            n_cmp++; if (OMemAddr !== RESET_PC) begin n_err++; $display("FAIL nrdy_addr cyc %0d got %h exp %h", k, OMemAddr, RESET_PC); end
            n_cmp++; if (OValid !== 1'b0) begin n_err++; $display("FAIL nrdy_valid cyc %0d got %b exp 0", k, OValid); end
            n_cmp++; if (OInst !== 32'h0) begin n_err++; $display("FAIL nrdy_inst cyc %0d got %h exp 0", k, OInst); end
        end
        fetch_one(32'h1111_2222, RESET_PC);
        fetch_one(32'h3333_4444, RESET_PC + 32'd4);
    endtask

    task automatic test_stall();
        do_reset();
        tick(1, 0, 0, 0, 32'h0, 32'h0);
        sb.push_back('{inst: 32'h2008_0001, pc4: RESET_PC + 32'd4});
        // Response cycle plus one more stalled cycle, then release.
        for (int k = 0; k < 3; k++) begin
            if (k == 0) tick(0, 1, 1, 0, 32'h0, 32'h2008_0001);
            else        tick(0, 0, (k == 1), 0, 32'h0, 32'hDEAD_BEEF);
            e = sb[0];
            n_cmp++; if (OValid !== 1'b1) begin n_err++; $display("FAIL stall_valid cyc %0d got %b exp 1", k, OValid); end
            n_cmp++; if (OInst !== e.inst) begin n_err++; $display("FAIL stall_inst cyc %0d got %h exp %h", k, OInst, e.inst); end
            n_cmp++; if (OPCAdd4 !== e.pc4) begin n_err++; $display("FAIL stall_pc4 cyc %0d got %h exp %h", k, OPCAdd4, e.pc4); end
            n_cmp++; if (OMemReq !== 1'b0) begin n_err++; $display("FAIL stall_req cyc %0d got %b exp 0", k, OMemReq); end
            n_cmp++; if (OMemAddr !== RESET_PC) begin n_err++; $display("FAIL stall_pc cyc %0d got %h exp %h", k, OMemAddr, RESET_PC); end
            if (k == 2) void'(sb.pop_front());
        end
        fetch_one(32'h2009_0002, RESET_PC + 32'd4);
    endtask

    task automatic test_redirect_wait();
        do_reset();
        tick(1, 0, 0, 0, 32'h0, 32'h0);
        tick(0, 0, 0, 1, 32'h0040_0100, 32'h0);
        n_cmp++; if (OValid !== 1'b0) begin n_err++; $display("FAIL rdw_redir_valid got %b exp 0", OValid); end
        tick(0, 0, 0, 0, 32'h0, 32'h0);
        n_cmp++; if (OMemReq !== 1'b0) begin n_err++; $display("FAIL rdw_drain_req got %b exp 0", OMemReq); end
        n_cmp++; if (OMemAddr !== 32'h0040_0100) begin n_err++; $display("FAIL rdw_drain_addr got %h exp 00400100", OMemAddr); end
        tick(0, 1, 0, 0, 32'h0, 32'hBAD0_0001);
        n_cmp++; if (OValid !== 1'b0) begin n_err++; $display("FAIL rdw_stale_valid got %b exp 0", OValid); end
        n_cmp++; if (OInst !== 32'h0) begin n_err++; $display("FAIL rdw_stale_inst got %h exp 0", OInst); end
        fetch_one(32'h0800_0040, 32'h0040_0100);
    endtask

    task automatic test_redirect_valid_stall();
        do_reset();
        tick(1, 0, 0, 0, 32'h0, 32'h0);
        tick(0, 1, 1, 1, 32'h0040_0203, 32'h2008_0001);
        n_cmp++; if (OValid !== 1'b0) begin n_err++; $display("FAIL rvs_valid got %b exp 0", OValid); end
        n_cmp++; if (OInst !== 32'h0) begin n_err++; $display("FAIL rvs_inst got %h exp 0", OInst); end
        tick(0, 0, 1, 0, 32'h0, 32'h0);
        n_cmp++; if (OValid !== 1'b0) begin n_err++; $display("FAIL rvs_no_hold got %b exp 0", OValid); end
        n_cmp++; if (OMemReq !== 1'b1) begin n_err++; $display("FAIL rvs_req got %b exp 1", OMemReq); end
        n_cmp++; if (OMemAddr !== 32'h0040_0200) begin n_err++; $display("FAIL rvs_addr got %h exp 00400200", OMemAddr); end
        n_cmp++; if (OPCAdd4 !== 32'h0040_0204) begin n_err++; $display("FAIL rvs_pc4 got %h exp 00400204", OPCAdd4); end
    endtask

    task automatic test_reset_wait();
        do_reset();
        fetch_one(32'h2008_0001, RESET_PC);
        tick(1, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        IMemReady = 0;
        reset = 1'b1;
        #1;
        n_cmp++; if (OMemReq !== 1'b0) begin n_err++; $display("FAIL rstw_req got %b exp 0", OMemReq); end
        n_cmp++; if (OMemAddr !== RESET_PC) begin n_err++; $display("FAIL rstw_addr got %h exp %h", OMemAddr, RESET_PC); end
        @(negedge clk);
        reset = 1'b0;
        tick(0, 1, 0, 0, 32'h0, 32'hBAD0_0BAD);
        n_cmp++; if (OValid !== 1'b0) begin n_err++; $display("FAIL rstw_late_valid got %b exp 0", OValid); end
        n_cmp++; if (OInst !== 32'h0) begin n_err++; $display("FAIL rstw_late_inst got %h exp 0", OInst); end
        n_cmp++; if (OMemAddr !== RESET_PC) begin n_err++; $display("FAIL rstw_rel_addr got %h exp %h", OMemAddr, RESET_PC); end
        fetch_one(32'h2009_0002, RESET_PC);
    endtask

    task automatic test_wrap();
        do_reset();
        tick(0, 0, 0, 1, 32'hFFFF_FFFF, 32'h0);
        n_cmp++; if (OMemReq !== 1'b0) begin n_err++; $display("FAIL wrap_redir_req got %b exp 0", OMemReq); end
        tick(0, 0, 0, 0, 32'h0, 32'h0);
        n_cmp++; if (OPCAdd4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4 got %h exp 0", OPCAdd4); end
        fetch_one(32'h0000_000C, 32'hFFFF_FFFC);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1;
        CStall = 0; CRedirect = 0; IRedirectPC = 0; IMemReady = 0; IMemValid = 0; IMemData = 0;
        test_reset();
        test_stream();
        test_not_ready();
        test_stall();
        test_redirect_wait();
        test_redirect_valid_stall();
        test_reset_wait();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
